data_peak_capture_buffer: RTL

- Parametrised single-clock successor to the stage-2 peak buffer: captures multi-lane ADC words into a circular buffer with programmable pre-trigger history.
- Tracks the peak sample of the post-trigger window, then serialises the whole window one sample per read request.
- Sits between the deserialised ADC data path (already moved to the SysClk domain) and the byte-wide readout/transmit logic.

---
 rtl/data_peak_capture_buffer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/data_peak_capture_buffer.sv
// data_peak_capture_buffer
// Captures multi-lane ADC words into a circular buffer that keeps PRE_WORDS
// words of history ahead of the trigger word. It tracks the peak sample of the
// post-trigger part of the window, then serialises the whole window one
// sample per read request.
// Optional build macro DATA_PEAK_SIGNED_EN: when defined, the peak search
// treats samples as two's-complement. Readout data is the same in both builds.
module data_peak_capture_buffer #(
  parameter int SAMPLE_W  = 8,
  parameter int LANES     = 4,
  parameter int DEPTH     = 64,
  parameter int PRE_WORDS = 8
) (
  input  logic                              SysClk,
  input  logic                              Reset_n,
  input  logic [LANES*SAMPLE_W-1:0]         DataIn,
  input  logic                              DataInValid,
  input  logic                              Arm,
  input  logic                              Trigger,
  input  logic                              DataRead,
  output logic                              DataAvailable,
  output logic                              DataValid,
  output logic [SAMPLE_W-1:0]               DataOut,
  output logic [SAMPLE_W-1:0]               PeakValue,
  output logic [$clog2(DEPTH*LANES)-1:0]    PeakIndex,
  output logic                              Busy
);

  localparam int AW         = $clog2(DEPTH);
  localparam int IW         = $clog2(DEPTH*LANES);
  localparam int LW         = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int POST_WORDS = DEPTH - PRE_WORDS;

  typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, READOUT} state_t;

  state_t                    state;
  logic [LANES*SAMPLE_W-1:0] mem [DEPTH];
  logic [AW-1:0]             wptr;
  logic [AW-1:0]             taddr;
  logic [AW-1:0]             fillCnt;
  logic [AW-1:0]             postCnt;
  logic [AW-1:0]             rdAddr;
  logic [LW-1:0]             rdLane;
  logic [IW-1:0]             rdCnt;
  logic [SAMPLE_W-1:0]       runMax;
  logic [IW-1:0]             runIdx;
  logic [SAMPLE_W-1:0]       wordMax;
  logic [IW-1:0]             wordOff;
  logic [IW-1:0]             wordIdx;
  logic [SAMPLE_W-1:0]       nextMax;
  logic [IW-1:0]             nextIdx;
  logic [LANES*SAMPLE_W-1:0] rdWord;
  logic [SAMPLE_W-1:0]       rdSample;
  logic                      wrEn;
  logic                      postWord;
  logic                      lastPost;
  logic                      rdAccept;

  // Strict "greater than" so that a tie keeps the earlier (lower index) sample
  function automatic logic sampleGreater(input logic [SAMPLE_W-1:0] a,
                                         input logic [SAMPLE_W-1:0] b);
`ifdef DATA_PEAK_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  assign wrEn     = DataInValid && (state == FILL || state == ARMED || state == POST);
  assign postWord = DataInValid && ((state == ARMED && Trigger) || state == POST);
  assign lastPost = (postCnt == AW'(POST_WORDS - 1));
  assign rdAccept = DataRead && DataAvailable;
  assign Busy     = (state != IDLE);

  // Peak of the incoming word across its lanes, merged with the running peak
  always_comb begin
    wordMax = DataIn[SAMPLE_W-1:0];
    wordOff = '0;
    for (int l = 1; l < LANES; l++) begin
      if (sampleGreater(DataIn[l*SAMPLE_W +: SAMPLE_W], wordMax)) begin
        wordMax = DataIn[l*SAMPLE_W +: SAMPLE_W];
        wordOff = IW'(l);
      end
    end
    wordIdx = IW'(PRE_WORDS*LANES) + IW'(postCnt) * IW'(LANES) + wordOff;
    if (postCnt == '0 || sampleGreater(wordMax, runMax)) begin
      nextMax = wordMax;
      nextIdx = wordIdx;
    end else begin
      nextMax = runMax;
      nextIdx = runIdx;
    end
  end

  // Lane select of the word at the current read address
  always_comb begin
    rdWord   = mem[rdAddr];
    rdSample = rdWord[SAMPLE_W-1:0];
    for (int l = 1; l < LANES; l++) begin
      if (rdLane == LW'(l)) rdSample = rdWord[l*SAMPLE_W +: SAMPLE_W];
    end
  end

  // Sample storage; left unreset so it can map onto block RAM
  always_ff @(posedge SysClk) begin
    if (wrEn) mem[wptr] <= DataIn;
  end

  // Capture/readout controller with registered outputs
  always_ff @(posedge SysClk or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= IDLE;
      wptr          <= '0;
      taddr         <= '0;
      fillCnt       <= '0;
      postCnt       <= '0;
      rdAddr        <= '0;
      rdLane        <= '0;
      rdCnt         <= '0;
      runMax        <= '0;
      runIdx        <= '0;
      DataAvailable <= 1'b0;
      DataValid     <= 1'b0;
      DataOut       <= '0;
      PeakValue     <= '0;
      PeakIndex     <= '0;
    end else begin
      DataValid <= 1'b0;
      if (wrEn) wptr <= wptr + 1'b1;
      case (state)
        IDLE: begin
          if (Arm) begin
            state     <= FILL;
            wptr      <= '0;
            fillCnt   <= '0;
            postCnt   <= '0;
            PeakValue <= '0;
            PeakIndex <= '0;
          end
        end
        FILL: begin
          if (DataInValid) begin
            fillCnt <= fillCnt + 1'b1;
            if (fillCnt == AW'(PRE_WORDS - 1)) state <= ARMED;
          end
        end
        ARMED, POST: begin
          if (postWord) begin
            if (state == ARMED) taddr <= wptr;
            runMax  <= nextMax;
            runIdx  <= nextIdx;
            postCnt <= postCnt + 1'b1;
            if (lastPost) begin
              // Window complete: publish the peak and rewind to the oldest word
              state         <= READOUT;
              DataAvailable <= 1'b1;
              PeakValue     <= nextMax;
              PeakIndex     <= nextIdx;
              rdAddr        <= ((state == ARMED) ? wptr : taddr) - AW'(PRE_WORDS);
              rdLane        <= '0;
              rdCnt         <= '0;
            end else if (state == ARMED) begin
              state <= POST;
            end
          end
        end
        READOUT: begin
          if (rdAccept) begin
            DataValid <= 1'b1;
            DataOut   <= rdSample;
            rdCnt     <= rdCnt + 1'b1;
            if (rdLane == LW'(LANES - 1)) begin
              rdLane <= '0;
              rdAddr <= rdAddr + 1'b1;
            end else begin
              rdLane <= rdLane + 1'b1;
            end
            if (rdCnt == IW'(DEPTH*LANES - 1)) begin
              DataAvailable <= 1'b0;
              state         <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
